hc595_driver: RTL

Upstream driver for the 74HC595 serial-in/parallel-out shift register. Takes a parallel word from system logic through a valid/ready handshake, serialises it MSB-first onto the chip's serial data input, generates the shift clock from the system clock, and pulses the latch clock once the word is fully shifted. Sits directly in front of `top` (one chip, or a daisy-chain through SQh) and drives its A, SHIFTCLOCK, LATCHCLOCK and OUTPUTENABLE pins.

---
 rtl/hc595_pkg.sv | 11 +
 rtl/hc595_tick_gen.sv | 23 ++
 rtl/hc595_driver.sv | 117 +++++++++++
 3 files changed

// File: rtl/hc595_pkg.sv
// Shared definitions for the 74HC595 upstream driver: FSM state encoding.
package hc595_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE     = 2'd0;
  localparam state_t SHIFT_LO = 2'd1;
  localparam state_t SHIFT_HI = 2'd2;
  localparam state_t LATCH    = 2'd3;

endpackage

// File: rtl/hc595_tick_gen.sv
// Half-period timer: one-cycle tick every DIV cycles, realigned by restart.
module hc595_tick_gen #(
  parameter int DIV = 4
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)                cnt <= '0;
    else if (restart || tick)  cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hc595_driver.sv
// Serialises a WIDTH-bit word MSB-first into a 74HC595 chain and pulses the latch.
// Optional HC595_READBACK_EN: captures the chain's previous contents from SQH into RDATA.
module hc595_driver
  import hc595_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  input  logic             BLANK,
  output logic             DONE,
  output logic             A,
  output logic             SHIFTCLOCK,
  output logic             LATCHCLOCK,
`ifdef HC595_READBACK_EN
  input  logic             SQH,
  output logic [WIDTH-1:0] RDATA,
`endif
  output logic             OUTPUTENABLE
);

  localparam int BW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic             tick, accept;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bitcnt;
  logic             ready_nxt, done_nxt, a_nxt, sck_nxt, lck_nxt;

  assign accept = (state == IDLE) && VALID && READY;

  hc595_tick_gen #(.DIV(DIV)) u_tick (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = SHIFT_LO;
      SHIFT_LO: if (tick)   state_nxt = SHIFT_HI;
      SHIFT_HI: if (tick)   state_nxt = (bitcnt == BW'(1)) ? LATCH : SHIFT_LO;
      LATCH:    if (tick)   state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (accept) begin
      shreg  <= DATA;
      bitcnt <= BW'(WIDTH);
    end else if (state == SHIFT_HI && tick) begin
      shreg  <= shreg << 1;
      bitcnt <= bitcnt - 1'b1;
    end
  end

  // Pins are registered from the current state, so they trail the FSM by one cycle;
  // READY alone must also drop on the accepting edge to block a double accept.
  always_comb begin
    ready_nxt = (state == IDLE) && !accept;
    sck_nxt   = (state == SHIFT_HI);
    lck_nxt   = (state == LATCH);
    done_nxt  = (state == IDLE) && LATCHCLOCK;
    a_nxt     = A;
    if (state == IDLE)          a_nxt = 1'b0;
    else if (state == SHIFT_LO) a_nxt = shreg[WIDTH-1];
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      READY        <= 1'b0;
      DONE         <= 1'b0;
      A            <= 1'b0;
      SHIFTCLOCK   <= 1'b0;
      LATCHCLOCK   <= 1'b0;
      OUTPUTENABLE <= 1'b1;
    end else begin
      READY        <= ready_nxt;
      DONE         <= done_nxt;
      A            <= a_nxt;
      SHIFTCLOCK   <= sck_nxt;
      LATCHCLOCK   <= lck_nxt;
      OUTPUTENABLE <= BLANK;
    end
  end

`ifdef HC595_READBACK_EN
  logic [WIDTH-1:0] cap;

  // SQH is sampled just before each shift-clock rise, i.e. the chain's old MSB first.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cap   <= '0;
      RDATA <= '0;
    end else begin
      if (state == SHIFT_LO && tick) cap <= {cap[WIDTH-2:0], SQH};
      if (done_nxt)                  RDATA <= cap;
    end
  end
`endif

endmodule
